// File: rtl/serial_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx_fifo
//  Purpose  : Byte buffer and send sequencer in front of serial_write (UART
//             TX). Words from the USB3300 receive parser are pushed at clk
//             rate into a circular FIFO. One send_data pulse is issued per
//             word, only while serial_write reports no transmission (TiP
//             low). A word leaves the FIFO only after serial_write
//             acknowledges it by raising TiP. A missed acknowledge causes a
//             retry, so the word is never lost.
//  Ports    : clk        in   reference clock (serial_write domain)
//             rstn       in   asynchronous active-low reset
//             wr_data    in   word from parser
//             wr_en      in   push wr_data this cycle
//             full       out  FIFO holds 2**ADDR_W words
//             empty      out  FIFO holds no words
//             level      out  occupancy, 0..2**ADDR_W
//             overflow   out  sticky, push attempted while full
//             tx_data    out  registered word/character to serial_write
//             send_data  out  one-cycle start pulse to serial_write
//             TiP        in   transmission-in-progress from serial_write
//  Options  : SERIAL_TX_FIFO_HEX_EN - when defined, each word is sent as
//             ASCII hex characters (uppercase), most-significant nibble
//             first. N_BITS must be a multiple of 4.
//  Revision : 1.0  initial release
// ============================================================================
module serial_tx_fifo #(
    parameter int N_BITS  = 8,
    parameter int ADDR_W  = 4,
    parameter int BUSY_TO = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N_BITS-1:0] wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [N_BITS-1:0] tx_data,
    output logic              send_data,
    input  logic              TiP
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PTR_W = ADDR_W + 1;
    localparam int CNT_W = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;

    // Pointers that differ only in the wrap bit mean the FIFO is full.
    localparam logic [PTR_W-1:0] PTR_MSB = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(BUSY_TO - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------
    logic [N_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic              overflow_q;
    logic              overflow_d;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_last;
    logic [N_BITS-1:0] w_rd_word;
    logic [N_BITS-1:0] w_tx_next;

    state_t            state_q;
    logic [CNT_W-1:0]  to_cnt_q;
    logic [N_BITS-1:0] tx_data_q;
    logic              send_q;

    assign w_full  = ((wr_ptr_q ^ rd_ptr_q) == PTR_MSB);
    assign w_empty = (wr_ptr_q == rd_ptr_q);

    // Full is evaluated on the current pointers, so a push into a full FIFO
    // is rejected even when a pop happens in the same cycle.
    assign w_push  = wr_en & ~w_full;

    // The word is retired only on the serial_write acknowledge of its last
    // character; a retry never advances the read pointer.
    assign w_pop   = (state_q == S_WAIT_BUSY) & TiP & w_last;

    assign w_rd_word = mem_q[rd_ptr_q[ADDR_W-1:0]];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (wr_en && w_full) begin
            overflow_d = 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: only locations between the pointers are read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Outgoing character selection
    // ------------------------------------------------------------------
`ifdef SERIAL_TX_FIFO_HEX_EN
    localparam int NIB_N = N_BITS / 4;
    localparam int NIB_W = (NIB_N > 1) ? $clog2(NIB_N) : 1;
    localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(NIB_N - 1);

    // Index of the nibble being sent; 0 is the most-significant nibble.
    logic [NIB_W-1:0] nib_q;
    logic [3:0]       w_nib;
    logic [7:0]       w_char;

    assign w_last = (nib_q == NIB_LAST);

    always_comb begin
        w_nib = 4'h0;
        for (int i = 0; i < NIB_N; i++) begin
            if (nib_q == NIB_W'(NIB_N - 1 - i)) begin
                w_nib = w_rd_word[4*i +: 4];
            end
        end
        // '0'..'9' then 'A'..'F'; 'A' - 10 = 0x37.
        if (w_nib < 4'd10) begin
            w_char = 8'h30 + {4'h0, w_nib};
        end else begin
            w_char = 8'h37 + {4'h0, w_nib};
        end
    end

    generate
        if (N_BITS == 8) begin : g_char_eq
            assign w_tx_next = w_char;
        end else if (N_BITS > 8) begin : g_char_wide
            assign w_tx_next = {{(N_BITS-8){1'b0}}, w_char};
        end else begin : g_char_narrow
            assign w_tx_next = w_char[N_BITS-1:0];
        end
    endgenerate
`else
    // Raw mode: every word is its own single character.
    assign w_last    = 1'b1;
    assign w_tx_next = w_rd_word;
`endif

    // ------------------------------------------------------------------
    // Send sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            to_cnt_q  <= '0;
            tx_data_q <= '0;
            send_q    <= 1'b0;
`ifdef SERIAL_TX_FIFO_HEX_EN
            nib_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Only start while the serializer is quiet.
                    if (!w_empty && !TiP) begin
                        tx_data_q <= w_tx_next;
                        send_q    <= 1'b1;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    send_q   <= 1'b0;
                    to_cnt_q <= '0;
                    state_q  <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (TiP) begin
                        state_q <= S_WAIT_DONE;
`ifdef SERIAL_TX_FIFO_HEX_EN
                        if (w_last) begin
                            nib_q <= '0;
                        end else begin
                            nib_q <= nib_q + NIB_W'(1);
                        end
`endif
                    end else if (to_cnt_q == TO_LAST) begin
                        // No acknowledge: go back and resend the same character.
                        state_q <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!TiP) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign full      = w_full;
    assign empty     = w_empty;
    assign level     = wr_ptr_q - rd_ptr_q;
    assign overflow  = overflow_q;
    assign tx_data   = tx_data_q;
    assign send_data = send_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_tx_fifo
//  Purpose  : Self-checking bench for serial_tx_fifo. A queue model of the
//             FIFO contents, a serial_write stand-in driving TiP, and
//             directed stimulus with literal expectations.
//  Options  : SERIAL_TX_FIFO_HEX_EN selects the hex-character scenario.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_tx_fifo;

    localparam int DEPTH   = 16;
    localparam int BUSY_TO = 4;
`ifdef SERIAL_TX_FIFO_HEX_EN
    localparam int NIB_N   = 2;
`endif

    logic       clk     = 1'b0;
    logic       rstn    = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en   = 1'b0;
    logic       TiP     = 1'b0;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic [7:0] tx_data;
    logic       send_data;

    serial_tx_fifo #(
        .N_BITS (8),
        .ADDR_W (4),
        .BUSY_TO(BUSY_TO)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .tx_data  (tx_data),
        .send_data(send_data),
        .TiP      (TiP)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

`ifdef SERIAL_TX_FIFO_HEX_EN
    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h41 + ({4'h0, n} - 8'd10);
    endfunction
`endif

    // ---------------- model state ----------------
    logic [7:0] mq[$];        // words the FIFO must hold
    bit         m_ovf;
    int         m_nib;
    int         win;          // edges left in which a TiP high counts as acknowledge
    logic [7:0] ack_log[$];   // tx_data of every acknowledged send
    int         send_times[$];
    bit         send_seen;
    bit         send_prev;
    logic [7:0] tx_seen;
    int         cyc = 0;

    // ---------------- serial_write stand-in ----------------
    int tip_mode = 0;         // 0 respond, 1 hold TiP high, 2 never respond
    int tip_hold = 20;
    int tip_cnt  = 0;
    bit tip_arm  = 0;

    always @(posedge clk) cyc++;

    // Model: acknowledge = TiP seen high within BUSY_TO edges after a send.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
            m_ovf = 1'b0;
            m_nib = 0;
            win   = 0;
        end else begin
            int sz;
            bit ack;
            sz  = mq.size();
            ack = 1'b0;
            if (win > 0) begin
                if (TiP) begin
                    ack = 1'b1;
                    win = 0;
                end else begin
                    win--;
                end
            end
            if (send_seen) win = BUSY_TO;
            if (ack) begin
                ack_log.push_back(tx_seen);
                if (mq.size() > 0) begin
`ifdef SERIAL_TX_FIFO_HEX_EN
                    if (m_nib == NIB_N - 1) begin
                        void'(mq.pop_front());
                        m_nib = 0;
                    end else begin
                        m_nib++;
                    end
`else
                    void'(mq.pop_front());
`endif
                end
            end
            if (wr_en) begin
                if (sz < DEPTH) mq.push_back(wr_data);
                else m_ovf = 1'b1;
            end
        end
    end

    // Compare on the falling edge, then update the TiP stand-in.
    always @(negedge clk) begin
        if (rstn) begin
            check("level", 32'(level), 32'(mq.size()));
            check("empty", 32'(empty), 32'(mq.size() == 0));
            check("full", 32'(full), 32'(mq.size() == DEPTH));
            check("overflow", 32'(overflow), 32'(m_ovf));
            if (send_data) begin
                send_times.push_back(cyc);
                check("send_while_tip", 32'(TiP), 32'd0);
                check("send_back_to_back", 32'(send_prev), 32'd0);
                if (mq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL send_when_empty: got send_data=1, expected 0");
                end else begin
`ifdef SERIAL_TX_FIFO_HEX_EN
                    check("tx_data", 32'(tx_data),
                          32'(hexc(4'((mq[0] >> (4 * (NIB_N - 1 - m_nib))) & 8'h0f))));
`else
                    check("tx_data", 32'(tx_data), 32'(mq[0]));
`endif
                end
            end
        end
        send_seen = send_data;
        send_prev = send_data;
        tx_seen   = tx_data;

        case (tip_mode)
            1: begin TiP = 1'b1; tip_cnt = 0; tip_arm = 1'b0; end
            2: begin TiP = 1'b0; tip_cnt = 0; tip_arm = 1'b0; end
            default: begin
                if (tip_arm) begin
                    TiP     = 1'b1;
                    tip_cnt = tip_hold;
                    tip_arm = 1'b0;
                end else if (tip_cnt > 0) begin
                    tip_cnt--;
                    if (tip_cnt == 0) TiP = 1'b0;
                end else begin
                    TiP = 1'b0;
                end
                if (send_data) tip_arm = 1'b1;
            end
        endcase
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!(empty && !TiP && tip_cnt == 0 && !tip_arm) && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles, level=%0d expected 0", name, n, level);
        end
        tick(2);
    endtask

    task automatic check_log(input string name, input logic [7:0] base, input int cnt);
        check({name, "_count"}, 32'(ack_log.size()), 32'(cnt));
        for (int i = 0; i < cnt && i < ack_log.size(); i++) begin
            check(name, 32'(ack_log[i]), 32'(base + 8'(i)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset is asynchronous: values must be cleared before any clock edge.
        #1 rstn = 1'b0;
        #1;
        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_send", 32'(send_data), 32'd0);
        check("rst_tx", 32'(tx_data), 32'd0);
        @(posedge clk);
        #1;
        tick(2);
        rstn = 1'b1;
        tick(1);

`ifndef SERIAL_TX_FIFO_HEX_EN
        // 1: single word, latency and pop on acknowledge.
        tip_mode = 0;
        tip_hold = 20;
        push(8'hA5);
        check("t1_level_after_push", 32'(level), 32'd1);
        tick(1);
        check("t1_send", 32'(send_data), 32'd1);
        check("t1_tx", 32'(tx_data), 32'hA5);
        tick(1);
        check("t1_level_before_ack", 32'(level), 32'd1);
        tick(1);
        check("t1_level_after_ack", 32'(level), 32'd0);
        wait_idle("t1_drain", 100);
        check("t1_empty", 32'(empty), 32'd1);
        check_log("t1_log", 8'hA5, 1);

        // 2: fill with TiP busy, overflow, then drain in order.
        ack_log.delete();
        tip_mode = 1;
        tick(2);
        for (int i = 0; i < 16; i++) push(8'(i));
        check("t2_full", 32'(full), 32'd1);
        check("t2_level16", 32'(level), 32'd16);
        check("t2_no_ovf_yet", 32'(overflow), 32'd0);
        push(8'h10);
        check("t2_overflow", 32'(overflow), 32'd1);
        check("t2_level_after_drop", 32'(level), 32'd16);
        tip_mode = 0;
        wait_idle("t2_drain", 800);
        check_log("t2_log", 8'h00, 16);

        // 3: no acknowledge -> periodic retries of the same word.
        ack_log.delete();
        send_times.delete();
        tip_mode = 2;
        push(8'h3C);
        tick(20);
        check("t3_level", 32'(level), 32'd1);
        check("t3_pulses", 32'(send_times.size() >= 3), 32'd1);
        if (send_times.size() >= 3) begin
            check("t3_period_a", 32'(send_times[1] - send_times[0]), 32'd6);
            check("t3_period_b", 32'(send_times[2] - send_times[1]), 32'd6);
        end
        check("t3_no_ack", 32'(ack_log.size()), 32'd0);
        tip_mode = 0;
        wait_idle("t3_drain", 100);
        check_log("t3_log", 8'h3C, 1);

        // 4: steady state at level 8 with push and pop in the same cycle.
        ack_log.delete();
        tip_mode = 1;
        tick(2);
        for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
        check("t4_level8", 32'(level), 32'd8);
        tip_hold = 3;
        tip_mode = 0;
        for (int i = 0; i < 32; i++) begin
            bit tp;
            int n;
            tp = TiP;
            n  = 0;
            do begin
                tp = TiP;
                @(negedge clk);
                #1;
                n++;
            end while (!(TiP && !tp) && n < 60);
            if (n >= 60) begin
                checks++;
                errors++;
                $display("FAIL t4_ack_timeout: got no TiP rise, expected one within 60 cycles");
            end
            wr_data = 8'h48 + 8'(i);
            wr_en   = 1'b1;
            @(posedge clk);
            #1;
            wr_en   = 1'b0;
            check("t4_level_hold", 32'(level), 32'd8);
        end
        wait_idle("t4_drain", 400);
        check_log("t4_log", 8'h40, 40);

        // 5: reset while a word is in flight.
        ack_log.delete();
        tip_hold = 20;
        tip_mode = 1;
        tick(2);
        for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
        tip_mode = 0;
        begin
            int n;
            n = 0;
            while (level != 5'd5 && n < 40) begin
                tick(1);
                n++;
            end
        end
        tick(3);
        check("t5_level5", 32'(level), 32'd5);
        check("t5_tip_busy", 32'(TiP), 32'd1);
        rstn = 1'b0;
        #1;
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_level0", 32'(level), 32'd0);
        check("t5_send", 32'(send_data), 32'd0);
        check("t5_overflow", 32'(overflow), 32'd0);
        tick(2);
        rstn = 1'b1;
        send_times.delete();
        tick(40);
        check("t5_no_send", 32'(send_times.size()), 32'd0);
        check("t5_still_empty", 32'(empty), 32'd1);
`else
        // 6: hex characters, single pop after the last one.
        ack_log.delete();
        tip_mode = 0;
        tip_hold = 5;
        push(8'h5E);
        begin
            int n;
            n = 0;
            while (ack_log.size() < 1 && n < 40) begin
                tick(1);
                n++;
            end
        end
        check("t6_level_mid", 32'(level), 32'd1);
        wait_idle("t6_drain", 100);
        check("t6_count", 32'(ack_log.size()), 32'd2);
        if (ack_log.size() >= 2) begin
            check("t6_char0", 32'(ack_log[0]), 32'h35);
            check("t6_char1", 32'(ack_log[1]), 32'h45);
        end
        check("t6_level_end", 32'(level), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
